// File: rtl/matrix_slot_allocator_pkg.sv
// Shared constants, state encoding and class helpers for the slot allocator.
// Build option: MATRIX_ALLOC_EVICT_EN (recycle the oldest entry of a full class).
package matrix_slot_allocator_pkg;

  localparam int DEF_NUM_SLOTS   = 20;
  localparam int DEF_SLOT_WORDS  = 25;
  localparam int DEF_MAX_PER_DIM = 2;
  localparam int NUM_CLASSES     = 25;
  localparam int DIM_MIN         = 1;
  localparam int DIM_MAX         = 5;
  localparam int ADDR_W          = 9;
  localparam int ADDR_SPACE      = 512;
  localparam int DIM_W           = 3;
  localparam int CLS_W           = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_GRANT = 2'd2,
    S_FAIL  = 2'd3
  } state_e;

  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d >= DIM_W'(DIM_MIN)) && (d <= DIM_W'(DIM_MAX));
  endfunction

  // Row-major class id, only meaningful when both dims pass dim_ok.
  function automatic logic [CLS_W-1:0] class_of(
    input logic [DIM_W-1:0] m,
    input logic [DIM_W-1:0] n
  );
    logic [CLS_W-1:0] r;
    logic [CLS_W-1:0] c;
    r = CLS_W'(m) - CLS_W'(1);
    c = CLS_W'(n) - CLS_W'(1);
    return r * CLS_W'(DIM_MAX) + c;
  endfunction

endpackage

// File: rtl/matrix_slot_allocator_scanner.sv
// Linear free-slot search: tests one slot per enabled cycle from index 0,
// reporting the first free index or exhaustion at the last slot.
module slot_free_scanner
  import matrix_slot_allocator_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 en_i,
  input  logic [NUM_SLOTS-1:0] free_i,
  output logic                 found_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 exhausted_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cur_free;
  logic             at_last;

  assign cur_free    = free_i[idx_q];
  assign at_last     = (idx_q == IDX_W'(NUM_SLOTS - 1));
  assign found_o     = en_i && cur_free;
  assign exhausted_o = en_i && !cur_free && at_last;
  assign idx_o       = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (start_i) begin
      idx_d = '0;
    end else if (en_i && !cur_free && !at_last) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/matrix_slot_allocator.sv
// Fixed-slot allocator for up to MAX_PER_DIM matrices per (m,n) class.
// Build option: MATRIX_ALLOC_EVICT_EN reuses a full class's oldest slot.
module matrix_slot_allocator
  import matrix_slot_allocator_pkg::*;
#(
  parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter int SLOT_WORDS  = DEF_SLOT_WORDS,
  parameter int MAX_PER_DIM = DEF_MAX_PER_DIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  input  logic [DIM_W-1:0]  alloc_m,
  input  logic [DIM_W-1:0]  alloc_n,
  input  logic              commit,
  input  logic              abort,
  output logic [ADDR_W-1:0] base_addr,
  output logic              alloc_ready,
  output logic              alloc_fail,
  input  logic              lookup_req,
  input  logic [DIM_W-1:0]  lookup_m,
  input  logic [DIM_W-1:0]  lookup_n,
  input  logic              lookup_k,
  output logic              lookup_done,
  output logic              lookup_hit,
  output logic [ADDR_W-1:0] lookup_addr,
  output logic [1:0]        class_count
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int PTR_W  = (MAX_PER_DIM > 1) ? $clog2(MAX_PER_DIM) : 1;
  localparam int CNT_W  = $clog2(MAX_PER_DIM + 1);

  if (NUM_SLOTS * SLOT_WORDS > ADDR_SPACE) begin : g_bad_cfg
    $error("slot table exceeds 9-bit address space");
  end

  function automatic logic [ADDR_W-1:0] base_of(input logic [SLOT_W-1:0] s);
    return ADDR_W'(s) * ADDR_W'(SLOT_WORDS);
  endfunction

  // Ring-buffer position arithmetic within a class.
  function automatic logic [PTR_W-1:0] ring(input int a, input int b);
    int s;
    s = a + b;
    if (s >= MAX_PER_DIM) s = s - MAX_PER_DIM;
    return PTR_W'(s);
  endfunction

  state_e                 state_q, state_d;
  logic [CLS_W-1:0]       cls_q;
  logic [SLOT_W-1:0]      slot_q;
  logic [NUM_SLOTS-1:0]   used_q;
  logic [SLOT_W-1:0]      ent_q [NUM_CLASSES][MAX_PER_DIM];
  logic [CNT_W-1:0]       cnt_q [NUM_CLASSES];
  logic [PTR_W-1:0]       old_q [NUM_CLASSES];

  logic                   req_ok;
  logic                   cls_full;
  logic                   scan_start;
  logic                   scan_en;
  logic                   found;
  logic                   exhausted;
  logic [SLOT_W-1:0]      scan_idx;
  logic [PTR_W-1:0]       wr_pos;

  logic                   lk_v_q;
  logic                   lk_ok_q;
  logic [CLS_W-1:0]       lk_cls_q;
  logic                   lk_k_q;
  logic [CNT_W-1:0]       lk_cnt;
  logic                   lk_hit;
  logic [PTR_W-1:0]       lk_pos;
  logic [ADDR_W-1:0]      lk_addr;
  logic                   done_q;
  logic                   hit_q;
  logic [ADDR_W-1:0]      laddr_q;
  logic [CNT_W-1:0]       lcnt_q;

  assign req_ok     = dim_ok(alloc_m) && dim_ok(alloc_n);
  assign cls_full   = (cnt_q[cls_q] == CNT_W'(MAX_PER_DIM));
  assign scan_start = (state_q == S_IDLE) && alloc_req && req_ok;
  assign scan_en    = (state_q == S_SCAN) && !cls_full;
  assign wr_pos     = ring(int'(old_q[cls_q]), int'(cnt_q[cls_q]));

  slot_free_scanner #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (SLOT_W)
  ) u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (scan_start),
    .en_i        (scan_en),
    .free_i      (~used_q),
    .found_o     (found),
    .idx_o       (scan_idx),
    .exhausted_o (exhausted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (alloc_req) state_d = req_ok ? S_SCAN : S_FAIL;
      end
      S_SCAN: begin
        if (cls_full) begin
`ifdef MATRIX_ALLOC_EVICT_EN
          state_d = S_GRANT;
`else
          state_d = S_FAIL;
`endif
        end else if (found) begin
          state_d = S_GRANT;
        end else if (exhausted) begin
          state_d = S_FAIL;
        end
      end
      S_GRANT: begin
        if (commit || abort) state_d = S_IDLE;
      end
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alloc_ready = (state_q == S_GRANT);
    alloc_fail  = (state_q == S_FAIL);
    base_addr   = alloc_ready ? base_of(slot_q) : '0;
  end

  // Reserved slots are marked used at grant so a later scan skips them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q  <= '0;
      slot_q <= '0;
      used_q <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        cnt_q[c] <= '0;
        old_q[c] <= '0;
        for (int e = 0; e < MAX_PER_DIM; e++) begin
          ent_q[c][e] <= '0;
        end
      end
    end else begin
      if (scan_start) cls_q <= class_of(alloc_m, alloc_n);
      if (scan_en && found) begin
        slot_q           <= scan_idx;
        used_q[scan_idx] <= 1'b1;
      end
`ifdef MATRIX_ALLOC_EVICT_EN
      // Evicted entry leaves the class now; its slot stays reserved.
      if ((state_q == S_SCAN) && cls_full) begin
        slot_q       <= ent_q[cls_q][old_q[cls_q]];
        old_q[cls_q] <= ring(int'(old_q[cls_q]), 1);
        cnt_q[cls_q] <= cnt_q[cls_q] - CNT_W'(1);
      end
`endif
      if (state_q == S_GRANT) begin
        if (abort) begin
          used_q[slot_q] <= 1'b0;
        end else if (commit) begin
          ent_q[cls_q][wr_pos] <= slot_q;
          cnt_q[cls_q]         <= cnt_q[cls_q] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    lk_cnt  = lk_ok_q ? cnt_q[lk_cls_q] : '0;
    lk_hit  = CNT_W'(lk_k_q) < lk_cnt;
    lk_pos  = ring(int'(old_q[lk_cls_q]), int'(lk_k_q));
    lk_addr = lk_hit ? base_of(ent_q[lk_cls_q][lk_pos]) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_v_q   <= 1'b0;
      lk_ok_q  <= 1'b0;
      lk_cls_q <= '0;
      lk_k_q   <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      laddr_q  <= '0;
      lcnt_q   <= '0;
    end else begin
      lk_v_q  <= (state_q == S_IDLE) && !alloc_req && lookup_req;
      lk_ok_q <= dim_ok(lookup_m) && dim_ok(lookup_n);
      lk_k_q  <= lookup_k;
      if (dim_ok(lookup_m) && dim_ok(lookup_n)) begin
        lk_cls_q <= class_of(lookup_m, lookup_n);
      end else begin
        lk_cls_q <= '0;
      end
      done_q <= lk_v_q;
      if (lk_v_q) begin
        hit_q   <= lk_hit;
        laddr_q <= lk_addr;
        lcnt_q  <= lk_cnt;
      end
    end
  end

  assign lookup_done = done_q;
  assign lookup_hit  = hit_q;
  assign lookup_addr = laddr_q;
  assign class_count = 2'(lcnt_q);

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Directed self-checking bench for matrix_slot_allocator.
// Honours MATRIX_ALLOC_EVICT_EN for the full-class scenario.
module tb_matrix_slot_allocator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0;
  logic [2:0] alloc_m = '0;
  logic [2:0] alloc_n = '0;
  logic       commit = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] base_addr;
  logic       alloc_ready;
  logic       alloc_fail;
  logic       lookup_req = 1'b0;
  logic [2:0] lookup_m = '0;
  logic [2:0] lookup_n = '0;
  logic       lookup_k = 1'b0;
  logic       lookup_done;
  logic       lookup_hit;
  logic [8:0] lookup_addr;
  logic [1:0] class_count;

  int checks = 0;
  int failures = 0;

  matrix_slot_allocator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_req   (alloc_req),
    .alloc_m     (alloc_m),
    .alloc_n     (alloc_n),
    .commit      (commit),
    .abort       (abort),
    .base_addr   (base_addr),
    .alloc_ready (alloc_ready),
    .alloc_fail  (alloc_fail),
    .lookup_req  (lookup_req),
    .lookup_m    (lookup_m),
    .lookup_n    (lookup_n),
    .lookup_k    (lookup_k),
    .lookup_done (lookup_done),
    .lookup_hit  (lookup_hit),
    .lookup_addr (lookup_addr),
    .class_count (class_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst_n = 1'b0;
    alloc_req = 1'b0;
    commit = 1'b0;
    abort = 1'b0;
    lookup_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic alloc(
    input  logic [2:0] m,
    input  logic [2:0] n,
    output logic       rdy,
    output logic       fl,
    output logic [8:0] base,
    output int         cyc
  );
    @(negedge clk);
    alloc_req = 1'b1;
    alloc_m = m;
    alloc_n = n;
    @(negedge clk);
    alloc_req = 1'b0;
    cyc = 1;
    while (!alloc_ready && !alloc_fail && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    rdy = alloc_ready;
    fl = alloc_fail;
    base = base_addr;
  endtask

  task automatic end_grant(input logic c, input logic a);
    commit = c;
    abort = a;
    @(negedge clk);
    commit = 1'b0;
    abort = 1'b0;
  endtask

  task automatic lookup(
    input  logic [2:0] m,
    input  logic [2:0] n,
    input  logic       k,
    output logic       hit,
    output logic [8:0] addr,
    output logic [1:0] cnt,
    output int         lat
  );
    @(negedge clk);
    lookup_req = 1'b1;
    lookup_m = m;
    lookup_n = n;
    lookup_k = k;
    @(negedge clk);
    lookup_req = 1'b0;
    lat = 1;
    while (!lookup_done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    hit = lookup_hit;
    addr = lookup_addr;
    cnt = class_count;
  endtask

  task automatic test_reset;
    logic h;
    logic [8:0] a;
    logic [1:0] c;
    int l;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({alloc_ready, alloc_fail, base_addr, lookup_done,
         lookup_hit, lookup_addr, class_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {alloc_ready, alloc_fail, base_addr});
    end
    do_reset();
    lookup(3'd1, 3'd1, 1'b0, h, a, c, l);
    checks++;
    if ({h, a, c} !== '0 || l != 2) begin
      failures++;
      $display("FAIL reset_lookup hit=%0d cnt=%0d lat=%0d exp 0/0/2",
               h, c, l);
    end
  endtask

  task automatic test_alloc_commit;
    logic r, f, h;
    logic [8:0] b, a;
    logic [1:0] c;
    int y, l;
    do_reset();
    alloc(3'd2, 3'd3, r, f, b, y);
    checks++;
    if (r !== 1'b1 || y > 3 || b !== 9'd0) begin
      failures++;
      $display("FAIL first_grant rdy=%0d cyc=%0d base=%0d exp 1/<=3/0",
               r, y, b);
    end
    alloc_req = 1'b1;
    alloc_m = 3'd1;
    alloc_n = 3'd1;
    @(negedge clk);
    alloc_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (alloc_ready !== 1'b1 || base_addr !== 9'd0) begin
      failures++;
      $display("FAIL grant_hold rdy=%0d base=%0d exp 1/0",
               alloc_ready, base_addr);
    end
    end_grant(1'b1, 1'b0);
    checks++;
    if (alloc_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_drop got=%0d exp=0", alloc_ready);
    end
    lookup(3'd2, 3'd3, 1'b0, h, a, c, l);
    checks++;
    if (h !== 1'b1 || a !== 9'd0 || c !== 2'd1 || l != 2) begin
      failures++;
      $display("FAIL lookup_23 hit=%0d addr=%0d cnt=%0d lat=%0d exp 1/0/1/2",
               h, a, c, l);
    end
    lookup(3'd1, 3'd1, 1'b0, h, a, c, l);
    checks++;
    if (h !== 1'b0 || c !== 2'd0) begin
      failures++;
      $display("FAIL ignored_req hit=%0d cnt=%0d exp 0/0", h, c);
    end
  endtask

  task automatic test_evict;
    logic r, f, h;
    logic [8:0] b, a;
    logic [1:0] c;
    int y, l;
    do_reset();
    alloc(3'd1, 3'd1, r, f, b, y);
    end_grant(1'b1, 1'b0);
    alloc(3'd1, 3'd1, r, f, b, y);
    checks++;
    if (r !== 1'b1 || b !== 9'd25) begin
      failures++;
      $display("FAIL second_11 rdy=%0d base=%0d exp 1/25", r, b);
    end
    end_grant(1'b1, 1'b0);
    alloc(3'd1, 3'd1, r, f, b, y);
`ifdef MATRIX_ALLOC_EVICT_EN
    checks++;
    if (r !== 1'b1 || b !== 9'd0 || y != 2) begin
      failures++;
      $display("FAIL evict_grant rdy=%0d base=%0d cyc=%0d exp 1/0/2",
               r, b, y);
    end
    end_grant(1'b1, 1'b0);
    lookup(3'd1, 3'd1, 1'b0, h, a, c, l);
    checks++;
    if (h !== 1'b1 || a !== 9'd25 || c !== 2'd2) begin
      failures++;
      $display("FAIL evict_k0 hit=%0d addr=%0d cnt=%0d exp 1/25/2",
               h, a, c);
    end
    lookup(3'd1, 3'd1, 1'b1, h, a, c, l);
    checks++;
    if (h !== 1'b1 || a !== 9'd0) begin
      failures++;
      $display("FAIL evict_k1 hit=%0d addr=%0d exp 1/0", h, a);
    end
`else
    checks++;
    if (f !== 1'b1 || r !== 1'b0 || y != 2) begin
      failures++;
      $display("FAIL full_class fail=%0d rdy=%0d cyc=%0d exp 1/0/2",
               f, r, y);
    end
    @(negedge clk);
    checks++;
    if (alloc_fail !== 1'b0) begin
      failures++;
      $display("FAIL fail_pulse got=%0d exp=0", alloc_fail);
    end
    lookup(3'd1, 3'd1, 1'b0, h, a, c, l);
    checks++;
    if (h !== 1'b1 || a !== 9'd0 || c !== 2'd2) begin
      failures++;
      $display("FAIL full_k0 hit=%0d addr=%0d cnt=%0d exp 1/0/2",
               h, a, c);
    end
`endif
  endtask

  task automatic test_full_table;
    logic r, f, h;
    logic [8:0] b, a;
    logic [1:0] c;
    int y, l;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 2; j++) begin
        alloc(3'(k / 5 + 1), 3'(k % 5 + 1), r, f, b, y);
        checks++;
        if (r !== 1'b1 || b !== 9'((2 * k + j) * 25)) begin
          failures++;
          $display("FAIL fill_%0d_%0d rdy=%0d base=%0d exp 1/%0d",
                   k, j, r, b, (2 * k + j) * 25);
        end
        end_grant(1'b1, 1'b0);
      end
    end
    alloc(3'd5, 3'd5, r, f, b, y);
    checks++;
    if (f !== 1'b1 || r !== 1'b0 || y != 21) begin
      failures++;
      $display("FAIL table_full fail=%0d rdy=%0d cyc=%0d exp 1/0/21",
               f, r, y);
    end
    @(negedge clk);
    checks++;
    if (alloc_fail !== 1'b0) begin
      failures++;
      $display("FAIL full_pulse got=%0d exp=0", alloc_fail);
    end
    lookup(3'd2, 3'd5, 1'b1, h, a, c, l);
    checks++;
    if (h !== 1'b1 || a !== 9'd475 || c !== 2'd2) begin
      failures++;
      $display("FAIL full_lk25 hit=%0d addr=%0d cnt=%0d exp 1/475/2",
               h, a, c);
    end
    lookup(3'd5, 3'd5, 1'b0, h, a, c, l);
    checks++;
    if (h !== 1'b0 || c !== 2'd0) begin
      failures++;
      $display("FAIL full_lk55 hit=%0d cnt=%0d exp 0/0", h, c);
    end
  endtask

  task automatic test_abort;
    logic r, f, h;
    logic [8:0] b, a;
    logic [1:0] c;
    int y, l;
    do_reset();
    alloc(3'd3, 3'd3, r, f, b, y);
    end_grant(1'b0, 1'b1);
    checks++;
    if (alloc_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_ready got=%0d exp=0", alloc_ready);
    end
    alloc(3'd4, 3'd4, r, f, b, y);
    checks++;
    if (r !== 1'b1 || b !== 9'd0) begin
      failures++;
      $display("FAIL after_abort rdy=%0d base=%0d exp 1/0", r, b);
    end
    end_grant(1'b1, 1'b0);
    lookup(3'd3, 3'd3, 1'b0, h, a, c, l);
    checks++;
    if (h !== 1'b0 || a !== 9'd0 || c !== 2'd0) begin
      failures++;
      $display("FAIL abort_lk hit=%0d addr=%0d cnt=%0d exp 0/0/0",
               h, a, c);
    end
    alloc(3'd3, 3'd3, r, f, b, y);
    end_grant(1'b1, 1'b1);
    lookup(3'd3, 3'd3, 1'b0, h, a, c, l);
    checks++;
    if (h !== 1'b0 || c !== 2'd0) begin
      failures++;
      $display("FAIL abort_wins hit=%0d cnt=%0d exp 0/0", h, c);
    end
    alloc(3'd5, 3'd1, r, f, b, y);
    checks++;
    if (r !== 1'b1 || b !== 9'd25) begin
      failures++;
      $display("FAIL slot_freed rdy=%0d base=%0d exp 1/25", r, b);
    end
    end_grant(1'b0, 1'b1);
  endtask

  task automatic test_invalid_dims;
    logic r, f, h;
    logic [8:0] b, a;
    logic [1:0] c;
    int y, l;
    do_reset();
    alloc(3'd0, 3'd3, r, f, b, y);
    checks++;
    if (f !== 1'b1 || y != 1) begin
      failures++;
      $display("FAIL m0 fail=%0d cyc=%0d exp 1/1", f, y);
    end
    @(negedge clk);
    checks++;
    if (alloc_fail !== 1'b0) begin
      failures++;
      $display("FAIL m0_pulse got=%0d exp=0", alloc_fail);
    end
    alloc(3'd2, 3'd6, r, f, b, y);
    checks++;
    if (f !== 1'b1 || y != 1) begin
      failures++;
      $display("FAIL n6 fail=%0d cyc=%0d exp 1/1", f, y);
    end
    lookup(3'd0, 3'd2, 1'b0, h, a, c, l);
    checks++;
    if (h !== 1'b0 || c !== 2'd0 || l != 2) begin
      failures++;
      $display("FAIL lk_invalid hit=%0d cnt=%0d lat=%0d exp 0/0/2",
               h, c, l);
    end
  endtask

  task automatic test_reset_in_grant;
    logic r, f, h;
    logic [8:0] b, a;
    logic [1:0] c;
    int y, l;
    do_reset();
    alloc(3'd2, 3'd2, r, f, b, y);
    end_grant(1'b1, 1'b0);
    alloc(3'd2, 3'd2, r, f, b, y);
    checks++;
    if (r !== 1'b1 || b !== 9'd25) begin
      failures++;
      $display("FAIL pre_rst rdy=%0d base=%0d exp 1/25", r, b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (alloc_ready !== 1'b0 || base_addr !== 9'd0) begin
      failures++;
      $display("FAIL async_rst rdy=%0d base=%0d exp 0/0",
               alloc_ready, base_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lookup(3'd2, 3'd2, 1'b0, h, a, c, l);
    checks++;
    if (h !== 1'b0 || c !== 2'd0) begin
      failures++;
      $display("FAIL rst_lk hit=%0d cnt=%0d exp 0/0", h, c);
    end
    alloc(3'd1, 3'd2, r, f, b, y);
    checks++;
    if (r !== 1'b1 || b !== 9'd0) begin
      failures++;
      $display("FAIL rst_freed rdy=%0d base=%0d exp 1/0", r, b);
    end
    end_grant(1'b0, 1'b1);
  endtask

  task automatic test_collision;
    logic seen_done;
    logic seen_rdy;
    do_reset();
    @(negedge clk);
    alloc_req = 1'b1;
    alloc_m = 3'd2;
    alloc_n = 3'd3;
    lookup_req = 1'b1;
    lookup_m = 3'd2;
    lookup_n = 3'd3;
    lookup_k = 1'b0;
    @(negedge clk);
    alloc_req = 1'b0;
    lookup_req = 1'b0;
    seen_done = 1'b0;
    seen_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen_done |= lookup_done;
      seen_rdy |= alloc_ready;
      @(negedge clk);
    end
    checks++;
    if (seen_done !== 1'b0 || seen_rdy !== 1'b1 || base_addr !== 9'd0) begin
      failures++;
      $display("FAIL collision done=%0d rdy=%0d base=%0d exp 0/1/0",
               seen_done, seen_rdy, base_addr);
    end
    end_grant(1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alloc_commit();
    test_evict();
    test_full_table();
    test_abort();
    test_invalid_dims();
    test_reset_in_grant();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_slot_allocator.md
MATRIX_SLOT_ALLOCATOR -- requirements
Module: matrix_slot_allocator

Interface
REQ-001 Parameters: NUM_SLOTS, default 20, number of fixed 25-word slots; SLOT_WORDS, default 25, words per slot; MAX_PER_DIM, default 2, matrices kept per (m,n) class.
REQ-002 Reset rst_n, asynchronous, active-low; clock clk.
REQ-003 Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- alloc_req  in  1  one-cycle request for a slot
- alloc_m  in  3  rows, 1..5
- alloc_n  in  3  columns, 1..5
- commit  in  1  writer finished (rx_done pulse)
- abort  in  1  writer disabled before commit
- base_addr  out  9  slot base = slot_idx*SLOT_WORDS
- alloc_ready  out  1  level; base_addr valid, writer may proceed
- alloc_fail  out  1  one-cycle pulse; no slot granted
- lookup_req  in  1  one-cycle query
- lookup_m, lookup_n  in  3 each  class queried
- lookup_k  in  1  entry index within class (0 = oldest)
- lookup_done  out  1  one-cycle pulse
- lookup_hit  out  1  entry exists, valid with lookup_done
- lookup_addr  out  9  base of hit entry, valid with lookup_done
- class_count  out  2  entries in last looked-up class, valid with lookup_done

Function
REQ-004 States: IDLE, SCAN, GRANT, FAIL; lookup is served only in IDLE.
REQ-005 IDLE: alloc_req with m or n outside 1..5 -> FAIL; valid request latches class = (m-1)*5+(n-1) -> SCAN; alloc_req has priority over a simultaneous lookup_req, which is dropped.
REQ-006 SCAN, class count < MAX_PER_DIM: test one slot per cycle from index 0 upward, first free slot is reserved -> GRANT; no free slot after NUM_SLOTS cycles -> FAIL.
REQ-007 SCAN, class count = MAX_PER_DIM: behaviour per REQ-016.
REQ-008 GRANT: alloc_ready=1 and base_addr held stable until commit or abort; request at most NUM_SLOTS+2 cycles after alloc_req.
REQ-009 GRANT+commit: entry appended to class (count+1, or oldest replaced and oldest pointer advanced on eviction), slot marked used, -> IDLE, alloc_ready=0 next cycle.
REQ-010 GRANT+abort: reserved slot released (evicted entry already freed stays freed, class count reduced), -> IDLE; commit and abort in the same cycle: abort wins.
REQ-011 alloc_req in SCAN, GRANT or FAIL is ignored.
REQ-012 FAIL: alloc_fail=1 for exactly one cycle, -> IDLE, no table change.
REQ-013 Lookup: lookup_done 2 cycles after lookup_req; hit when lookup_k < class_count; lookup_addr=0 on miss; invalid m/n -> miss, class_count=0.
REQ-014 Address arithmetic 9-bit unsigned; NUM_SLOTS*SLOT_WORDS <= 512 (checked at elaboration).

Reset
REQ-015 Reset at any time (including GRANT): all slots free, all class counts and oldest pointers 0, state IDLE, every output 0.

Configuration
REQ-016 MATRIX_ALLOC_EVICT_EN defined: full class -> oldest entry's slot reused directly -> GRANT in 1 cycle; undefined: full class -> FAIL.

Structure
REQ-017 Shared package: NUM_SLOTS, SLOT_WORDS, MAX_PER_DIM, class count 25, state encoding, dimension limits 1..5.
REQ-018 One sub-module, slot_free_scanner: free-slot bit vector in, one-per-cycle search, reports index or exhaustion.

Verification
REQ-019 Alloc (2,3) from reset, then commit -> alloc_ready within 3 cycles, base_addr=0; lookup (2,3,k=0) -> hit, lookup_addr=0, class_count=1.
REQ-020 Three allocs (1,1) with commits, evict enabled -> bases 0, 25, 0; lookup k=0 -> 25; without macro, third alloc -> alloc_fail pulse.
REQ-021 20 commits over 10 classes, then alloc (5,5) -> alloc_fail after 21 cycles, table unchanged.
REQ-022 Alloc (3,3), abort in GRANT -> next alloc (4,4) gets base_addr=0; lookup (3,3,0) -> miss, class_count=0.
REQ-023 Alloc m=0 or n=6 -> alloc_fail pulse next cycle; rst_n low during GRANT -> alloc_ready=0 immediately, all lookups miss.
REQ-024 alloc_req and lookup_req same cycle in IDLE -> allocation proceeds, no lookup_done.
